// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: width limits and a behavioural reference add.
package arith_pkg;

  localparam int unsigned FA_DEFAULT_WIDTH = 1;
  localparam int unsigned FA_MAX_WIDTH     = 64;

  // Behavioural {carry, sum} of a + b + cin, computed with the native adder.
  // The operands are zero-extended to FA_MAX_WIDTH bits. For a WIDTH-bit
  // caller, bits [WIDTH-1:0] of the result are the sum and bit WIDTH is the
  // carry.
  function automatic logic [FA_MAX_WIDTH:0] fa_ref(
    input logic [FA_MAX_WIDTH-1:0] a,
    input logic [FA_MAX_WIDTH-1:0] b,
    input logic                    cin
  );
    logic [FA_MAX_WIDTH:0] r;
    r = {1'b0, a} + {1'b0, b} + {{FA_MAX_WIDTH{1'b0}}, cin};
    return r;
  endfunction

endpackage

// File: rtl/full_adder_fa_cell.sv
// Single-bit combinational full adder cell used to build the ripple chain.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum is the three-input parity; carry is the three-input majority.
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder: {CARRY, SUM} = A + B + Cin, one cycle later.
module full_adder
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = FA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] SUM,
  output logic             CARRY
);

  // Reject widths the ripple chain is not intended to cover.
  if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_width_check
    $error("full_adder: WIDTH=%0d outside legal range 1..%0d", WIDTH, FA_MAX_WIDTH);
  end

  // carry[i] feeds bit i; carry[WIDTH] is the final carry-out.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_c;

  assign carry[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    fa_cell u_cell (
      .a  (A[i]),
      .b  (B[i]),
      .ci (carry[i]),
      .s  (sum_c[i]),
      .co (carry[i+1])
    );
  end

  // Output register: captures the ripple result every edge, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SUM   <= '0;
      CARRY <= 1'b0;
    end else begin
      SUM   <= sum_c;
      CARRY <= carry[WIDTH];
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH = 1, 8 and 16 with a queue scoreboard.
module tb_full_adder;
  import arith_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  logic        a1, b1, c1, s1, co1;
  logic [7:0]  a8, b8, s8;
  logic        c8, co8;
  logic [15:0] a16, b16, s16;
  logic        c16, co16;

  int checks = 0;
  int errors = 0;

  logic [64:0] q1[$];
  logic [64:0] q8[$];
  logic [64:0] q16[$];

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .Cin(c1), .SUM(s1), .CARRY(co1)
  );
  full_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .Cin(c8), .SUM(s8), .CARRY(co8)
  );
  full_adder #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .A(a16), .B(b16), .Cin(c16), .SUM(s16), .CARRY(co16)
  );

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic flush();
    q1.delete();
    q8.delete();
    q16.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_w1"},  {63'b0, co1, s1},   65'h0);
    check({tag, "_w8"},  {56'b0, co8, s8},   65'h0);
    check({tag, "_w16"}, {48'b0, co16, s16}, 65'h0);
  endtask

  // Record expectations for the current inputs, then compare one edge later.
  task automatic tick();
    logic [64:0] r;
    r = fa_ref(64'(a1), 64'(b1), c1);
    q1.push_back(r & 65'h3);
    r = fa_ref(64'(a8), 64'(b8), c8);
    q8.push_back(r & 65'h1FF);
    r = fa_ref(64'(a16), 64'(b16), c16);
    q16.push_back(r & 65'h1FFFF);
    @(posedge clk);
    #1;
    if (q1.size() == 0 || q8.size() == 0 || q16.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed=empty expected=entry");
    end else begin
      check("sb_w1",  {63'b0, co1, s1},   q1.pop_front());
      check("sb_w8",  {56'b0, co8, s8},   q8.pop_front());
      check("sb_w16", {48'b0, co16, s16}, q16.pop_front());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] tbl [8];
    tbl = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    rst_n = 1'b0;
    a1 = 0; b1 = 0; c1 = 0;
    a8 = '0; b8 = '0; c8 = 0;
    a16 = '0; b16 = '0; c16 = 0;

    // Reset state with clock running.
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_state");

    // Reset held with all-ones inputs: outputs stay 0, no edge in between.
    a1 = 1; b1 = 1; c1 = 1;
    #2;
    check_all_zero("reset_ones");
    @(posedge clk);
    #1;
    check_all_zero("reset_ones_edge");

    // Release between edges; first edge captures 1+1+1.
    @(negedge clk);
    rst_n = 1'b1;
    flush();
    tick();
    check("release_first", {63'b0, co1, s1}, 65'h3);

    // Exhaustive single-bit table, one vector per cycle.
    for (int v = 0; v < 8; v++) begin
      logic [2:0] vv;
      vv = 3'(v);
      {a1, b1, c1} = vv;
      tick();
      check($sformatf("exh_%0d", v), {63'b0, co1, s1}, {63'b0, tbl[v]});
    end

    // Mid-stream reset while SUM=1.
    a1 = 1; b1 = 0; c1 = 0;
    tick();
    check("pre_mid_reset", {63'b0, co1, s1}, 65'h1);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset_async");
    flush();
    @(posedge clk);
    #1;
    check_all_zero("mid_reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all_zero("mid_reset_released");
    tick();
    check("mid_reset_first", {63'b0, co1, s1}, 65'h1);

    // WIDTH=8 wrap cases.
    a8 = 8'hFF; b8 = 8'h00; c8 = 1;
    tick();
    check("w8_wrap0", {56'b0, co8, s8}, 65'h100);
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1;
    tick();
    check("w8_wrapff", {56'b0, co8, s8}, 65'h1FF);

    // WIDTH=8 latency: back-to-back operands give back-to-back results.
    a8 = 8'h12; b8 = 8'h34; c8 = 0;
    tick();
    check("w8_lat0", {56'b0, co8, s8}, 65'h046);
    a8 = 8'h01; b8 = 8'h01;
    tick();
    check("w8_lat1", {56'b0, co8, s8}, 65'h002);

    // WIDTH=16 corners followed by random vectors.
    a16 = 16'hFFFF; b16 = 16'h0000; c16 = 1;
    tick();
    check("w16_wrap", {48'b0, co16, s16}, 65'h10000);
    for (int n = 0; n < 10000; n++) begin
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      c16 = 1'($urandom);
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      c8  = 1'($urandom);
      {a1, b1, c1} = 3'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
